// File: rtl/fetch_control_unit.sv
// Multicycle fetch/decode/control sequencer: fetches over a req/valid handshake,
// decodes a MIPS subset and drives datapath controls with strobes only in WRITEBACK.
module fetch_control_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instruction,
    output logic        RegDst,
    output logic        MemRead,
    output logic        MemtoReg,
    output logic [3:0]  ALUCtrl,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        busy,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [31:0] instr_count
);

    localparam int unsigned TW = $clog2(FETCH_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALTED
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [31:0] instr_q, instr_d;
    logic [1:0]  fault_q, fault_d;
    logic        regdst_q, regdst_d;
    logic        memread_q, memread_d;
    logic        memtoreg_q, memtoreg_d;
    logic        alusrc_q, alusrc_d;
    logic [3:0]  aluctrl_q, aluctrl_d;
    logic        wreg_q, wreg_d;
    logic        wmem_q, wmem_d;
    logic        regwrite_q, regwrite_d;
    logic        memwrite_q, memwrite_d;

    logic        dec_ok, dec_halt, dec_regdst, dec_memread, dec_memtoreg, dec_alusrc;
    logic        dec_wreg, dec_wmem;
    logic [3:0]  dec_alu;

    always_comb begin
        dec_ok       = 1'b0;
        dec_halt     = 1'b0;
        dec_regdst   = 1'b0;
        dec_memread  = 1'b0;
        dec_memtoreg = 1'b0;
        dec_alusrc   = 1'b0;
        dec_wreg     = 1'b0;
        dec_wmem     = 1'b0;
        dec_alu      = 4'b0000;
        unique case (instr_q[31:26])
            6'h00: begin
                dec_regdst = 1'b1;
                dec_wreg   = 1'b1;
                dec_ok     = 1'b1;
                unique case (instr_q[5:0])
                    6'h20:   dec_alu = 4'b0010;
                    6'h22:   dec_alu = 4'b0110;
                    6'h24:   dec_alu = 4'b0000;
                    6'h25:   dec_alu = 4'b0001;
                    6'h27:   dec_alu = 4'b1100;
                    6'h2A:   dec_alu = 4'b0111;
                    default: dec_ok  = 1'b0;
                endcase
            end
            6'h23: begin
                dec_ok       = 1'b1;
                dec_alusrc   = 1'b1;
                dec_alu      = 4'b0010;
                dec_memread  = 1'b1;
                dec_memtoreg = 1'b1;
                dec_wreg     = 1'b1;
            end
            6'h2B: begin
                dec_ok     = 1'b1;
                dec_alusrc = 1'b1;
                dec_alu    = 4'b0010;
                dec_wmem   = 1'b1;
            end
            6'h08: begin
                dec_ok     = 1'b1;
                dec_alusrc = 1'b1;
                dec_alu    = 4'b0010;
                dec_wreg   = 1'b1;
            end
            6'h3F:   dec_halt = 1'b1;
            default: dec_ok   = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        instr_d    = instr_q;
        fault_d    = fault_q;
        regdst_d   = regdst_q;
        memread_d  = memread_q;
        memtoreg_d = memtoreg_q;
        alusrc_d   = alusrc_q;
        aluctrl_d  = aluctrl_q;
        wreg_d     = wreg_q;
        wmem_d     = wmem_q;
        regwrite_d = 1'b0;
        memwrite_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    tcnt_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end else if (tcnt_q == TW'(FETCH_TIMEOUT - 1)) begin
                    fault_d = 2'b10;
                    state_d = S_HALTED;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_DECODE: begin
                if (dec_halt) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_HALTED;
                end else if (!dec_ok) begin
                    fault_d = 2'b01;
                    state_d = S_HALTED;
                end else begin
                    regdst_d   = dec_regdst;
                    memread_d  = dec_memread;
                    memtoreg_d = dec_memtoreg;
                    alusrc_d   = dec_alusrc;
                    aluctrl_d  = dec_alu;
                    wreg_d     = dec_wreg;
                    wmem_d     = dec_wmem;
                    state_d    = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                // Strobes are registered here so they appear only for the WRITEBACK cycle.
                regwrite_d = wreg_q;
                memwrite_d = wmem_q;
                state_d    = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                pc_d       = pc_q + 32'd4;
                cnt_d      = cnt_q + 32'd1;
                regdst_d   = 1'b0;
                memread_d  = 1'b0;
                memtoreg_d = 1'b0;
                alusrc_d   = 1'b0;
                aluctrl_d  = '0;
                wreg_d     = 1'b0;
                wmem_d     = 1'b0;
                tcnt_d     = '0;
                state_d    = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            instr_q    <= '0;
            fault_q    <= '0;
            regdst_q   <= 1'b0;
            memread_q  <= 1'b0;
            memtoreg_q <= 1'b0;
            alusrc_q   <= 1'b0;
            aluctrl_q  <= '0;
            wreg_q     <= 1'b0;
            wmem_q     <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
            regdst_q   <= regdst_d;
            memread_q  <= memread_d;
            memtoreg_q <= memtoreg_d;
            alusrc_q   <= alusrc_d;
            aluctrl_q  <= aluctrl_d;
            wreg_q     <= wreg_d;
            wmem_q     <= wmem_d;
            regwrite_q <= regwrite_d;
            memwrite_q <= memwrite_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign RegDst      = regdst_q;
    assign MemRead     = memread_q;
    assign MemtoReg    = memtoreg_q;
    assign ALUCtrl     = aluctrl_q;
    assign ALUSrc      = alusrc_q;
    assign RegWrite    = regwrite_q;
    assign MemWrite    = memwrite_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted      = (state_q == S_HALTED);
    assign fault       = fault_q;
    assign instr_count = cnt_q;

endmodule
